alu_issue_stage: RTL and testbench

ID/EX boundary register of the RISC-V core: decodes the instruction fields for OP, OP-IMM, LOAD and STORE, and generates the ALU control code from the `common` package (`ALU_ADD`, `ALU_SUB`, `ALU_AND`, `ALU_OR`, `ALU_XOR`). It registers `left_operand`/`right_operand` for the combinational ALU behind a valid/ready handshake, with stall and flush. Shift and compare opcodes have no ALU support yet and are flagged illegal.

---
 rtl/alu_issue_stage.sv | 164 ++++++++++++++++
 tb/tb_alu_issue_stage.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// ID/EX boundary register: decodes OP/OP-IMM/LOAD/STORE into ALU
// control and operands behind a valid/ready handshake.
package common;
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
endpackage

module alu_issue_stage
  import common::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instruction,
  input  logic [31:0]      rs1_data,
  input  logic [31:0]      rs2_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       alu_control,
  output logic [31:0]      left_operand,
  output logic [31:0]      right_operand,
  output logic [31:0]      store_data,
  output logic [4:0]       rd,
  output logic             reg_write,
  output logic             illegal,
  output logic [CNT_W-1:0] issued_count
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd_f;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic        is_op;
  logic        is_imm;
  logic        is_load;
  logic        is_store;
  logic        accept;

  logic [3:0]  d_ctrl;
  logic [31:0] d_right;
  logic        d_ill;
  logic        d_wr;

  assign opcode = instruction[6:0];
  assign funct3 = instruction[14:12];
  assign funct7 = instruction[31:25];
  assign rd_f   = instruction[11:7];

  assign imm_i = {{20{instruction[31]}}, instruction[31:20]};
  assign imm_s = {{20{instruction[31]}},
                  instruction[31:25], instruction[11:7]};

  assign is_op    = opcode == 7'b0110011;
  assign is_imm   = opcode == 7'b0010011;
  assign is_load  = opcode == 7'b0000011;
  assign is_store = opcode == 7'b0100011;

  assign in_ready = flush | ~out_valid | out_ready;
  assign accept   = in_valid & in_ready & ~flush;

  always_comb begin
    d_ctrl  = ALU_ADD;
    d_right = rs2_data;
    d_ill   = 1'b1;
    unique case (1'b1)
      is_op: begin
        unique case (funct3)
          3'b000: begin
            if (funct7 == 7'b0000000) begin
              d_ill = 1'b0;
            end else if (funct7 == 7'b0100000) begin
              d_ctrl = ALU_SUB;
              d_ill  = 1'b0;
            end
          end
          3'b100: begin
            d_ctrl = ALU_XOR;
            d_ill  = funct7 != 7'b0;
          end
          3'b110: begin
            d_ctrl = ALU_OR;
            d_ill  = funct7 != 7'b0;
          end
          3'b111: begin
            d_ctrl = ALU_AND;
            d_ill  = funct7 != 7'b0;
          end
          default: ;
        endcase
      end
      is_imm: begin
        d_right = imm_i;
        unique case (funct3)
          3'b000: d_ill = 1'b0;
          3'b100: begin
            d_ctrl = ALU_XOR;
            d_ill  = 1'b0;
          end
          3'b110: begin
            d_ctrl = ALU_OR;
            d_ill  = 1'b0;
          end
          3'b111: begin
            d_ctrl = ALU_AND;
            d_ill  = 1'b0;
          end
          default: ;
        endcase
      end
      is_load: begin
        d_right = imm_i;
        d_ill   = 1'b0;
      end
      is_store: begin
        d_right = imm_s;
        d_ill   = 1'b0;
      end
      default: ;
    endcase
    // illegal ops still go to execute so the trap logic sees them
    if (d_ill) d_ctrl = ALU_ADD;
    d_wr = ~d_ill & ~is_store & (rd_f != 5'd0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid     <= 1'b0;
      alu_control   <= ALU_ADD;
      left_operand  <= '0;
      right_operand <= '0;
      store_data    <= '0;
      rd            <= '0;
      reg_write     <= 1'b0;
      illegal       <= 1'b0;
      issued_count  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      reg_write <= 1'b0;
      illegal   <= 1'b0;
    end else if (accept) begin
      out_valid     <= 1'b1;
      alu_control   <= d_ctrl;
      left_operand  <= rs1_data;
      right_operand <= d_right;
      store_data    <= rs2_data;
      rd            <= rd_f;
      reg_write     <= d_wr;
      illegal       <= d_ill;
      if (!d_ill) issued_count <= issued_count + 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: vector table plus
// stall/flush/reset sequences.
module tb_alu_issue_stage;
  import common::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instruction;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  alu_control;
  logic [31:0] left_operand;
  logic [31:0] right_operand;
  logic [31:0] store_data;
  logic [4:0]  rd;
  logic        reg_write;
  logic        illegal;
  logic [31:0] issued_count;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  alu_issue_stage #(.CNT_W(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .instruction   (instruction),
    .rs1_data      (rs1_data),
    .rs2_data      (rs2_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .alu_control   (alu_control),
    .left_operand  (left_operand),
    .right_operand (right_operand),
    .store_data    (store_data),
    .rd            (rd),
    .reg_write     (reg_write),
    .illegal       (illegal),
    .issued_count  (issued_count)
  );

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [3:0]  ctrl;
    logic [31:0] right;
    logic [4:0]  rd;
    logic        wr;
    logic        ill;
  } vec_t;

  vec_t vt[13];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic chk_vec(input vec_t v);
    chk({v.name, ".valid"}, 32'(out_valid), 32'd1);
    chk({v.name, ".ctrl"}, 32'(alu_control), 32'(v.ctrl));
    chk({v.name, ".left"}, left_operand, v.rs1);
    chk({v.name, ".right"}, right_operand, v.right);
    chk({v.name, ".store"}, store_data, v.rs2);
    chk({v.name, ".rd"}, 32'(rd), 32'(v.rd));
    chk({v.name, ".wr"}, 32'(reg_write), 32'(v.wr));
    chk({v.name, ".ill"}, 32'(illegal), 32'(v.ill));
    chk({v.name, ".cnt"}, issued_count, 32'(exp_cnt));
  endtask

  task automatic drive(input vec_t v);
    instruction = v.instr;
    rs1_data    = v.rs1;
    rs2_data    = v.rs2;
    in_valid    = 1'b1;
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, ".valid"}, 32'(out_valid), 32'd0);
    chk({nm, ".ctrl"}, 32'(alu_control), 32'(ALU_ADD));
    chk({nm, ".left"}, left_operand, 32'd0);
    chk({nm, ".right"}, right_operand, 32'd0);
    chk({nm, ".store"}, store_data, 32'd0);
    chk({nm, ".rd"}, 32'(rd), 32'd0);
    chk({nm, ".wr"}, 32'(reg_write), 32'd0);
    chk({nm, ".ill"}, 32'(illegal), 32'd0);
    chk({nm, ".cnt"}, issued_count, 32'd0);
  endtask

  initial begin
    vt[0]  = '{"add", 32'h002081B3, 5, 7,
               ALU_ADD, 7, 3, 1, 0};
    vt[1]  = '{"sub", 32'h40208133, 10, 3,
               ALU_SUB, 3, 2, 1, 0};
    vt[2]  = '{"addi_m1", 32'hFFF00093, 0, 9,
               ALU_ADD, 32'hFFFFFFFF, 1, 1, 0};
    vt[3]  = '{"sw", 32'h0020A423, 32'h100, 32'hAB,
               ALU_ADD, 8, 8, 0, 0};
    vt[4]  = '{"slli", 32'h00109093, 4, 6,
               ALU_ADD, 1, 1, 0, 1};
    vt[5]  = '{"xor", 32'h007342B3, 32'hF0F0, 32'h0FF0,
               ALU_XOR, 32'h0FF0, 5, 1, 0};
    vt[6]  = '{"ori_x0", 32'h7FF0E013, 1, 2,
               ALU_OR, 32'h7FF, 0, 0, 0};
    vt[7]  = '{"andi_min", 32'h80017213, 32'h1234, 0,
               ALU_AND, 32'hFFFFF800, 4, 1, 0};
    vt[8]  = '{"lw_m4", 32'hFFC1A483, 32'h2000, 5,
               ALU_ADD, 32'hFFFFFFFC, 9, 1, 0};
    vt[9]  = '{"xor_f7", 32'h4020C1B3, 11, 12,
               ALU_ADD, 12, 3, 0, 1};
    vt[10] = '{"lui", 32'h000002B7, 13, 14,
               ALU_ADD, 14, 5, 0, 1};
    vt[11] = '{"and", 32'h003170B3, 32'hFF00, 32'h0F0F,
               ALU_AND, 32'h0F0F, 1, 1, 0};
    vt[12] = '{"sw_m1", 32'hFE512FA3, 32'h40, 32'h55,
               ALU_ADD, 32'hFFFFFFFF, 31, 0, 0};

    reset = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    instruction = '0;
    rs1_data = '0;
    rs2_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset("rst");
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      drive(vt[i]);
      #1;
      chk({vt[i].name, ".in_ready"}, 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      if (!vt[i].ill) exp_cnt++;
      chk_vec(vt[i]);
    end

    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("drain.valid", 32'(out_valid), 32'd0);

    drive(vt[0]);
    @(posedge clk);
    #1;
    exp_cnt++;
    chk_vec(vt[0]);
    out_ready = 1'b0;
    drive(vt[1]);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("stall.in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      chk_vec(vt[0]);
    end

    flush = 1'b1;
    #1;
    chk("flush.in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("flush.valid", 32'(out_valid), 32'd0);
    chk("flush.wr", 32'(reg_write), 32'd0);
    chk("flush.cnt", issued_count, 32'(exp_cnt));

    drive(vt[4]);
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    chk_vec(vt[4]);
    drive(vt[0]);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush2.valid", 32'(out_valid), 32'd0);
    chk("flush2.ill", 32'(illegal), 32'd0);
    chk("flush2.cnt", issued_count, 32'(exp_cnt));

    out_ready = 1'b1;
    drive(vt[5]);
    @(posedge clk);
    #1;
    exp_cnt++;
    chk_vec(vt[5]);
    #2;
    reset = 1'b1;
    #1;
    chk_reset("arst");
    @(posedge clk);
    #1;
    reset = 1'b0;
    in_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running, want finished");
    $fatal(1);
  end

endmodule
